// File: rtl/spectrum_pkg.sv
// Shared sizes, FSM states and the 8-bit saturation helper for the spectrum frame buffer.
package spectrum_pkg;
    localparam int NUM_BINS = 512;
    localparam int BIN_AW   = 9;
    localparam int BIN_W    = 8;

    typedef enum logic [0:0] {FILL, WAIT_SWAP} state_t;

    function automatic logic [BIN_W-1:0] sat8(input logic [31:0] x);
        return (x > 32'd255) ? 8'hFF : x[BIN_W-1:0];
    endfunction
endpackage

// File: rtl/spectrum_bank_ram.sv
// Simple dual-port 512x8 bin store with synchronous write.
// Latency: read data registered, valid 1 cycle after raddr.
// Backpressure: none; one write and one read every cycle.
module spectrum_bank_ram
    import spectrum_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [BIN_AW-1:0] waddr,
    input  logic [BIN_W-1:0]  wdata,
    input  logic [BIN_AW-1:0] raddr,
    output logic [BIN_W-1:0]  rdata
);
    logic [BIN_W-1:0] mem [NUM_BINS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/spectrum_frame_buffer.sv
// Double-buffered 512-bin bar-height store; banks swap only on vblank. PEAK_HOLD_EN adds decaying peak hold.
// Latency: data valid 1 cycle after address; write side 1 bin/clk (1 bin per 2 clk with PEAK_HOLD_EN).
// Backpressure: s_ready low from frame completion until the next vblank, and during the post-reset peak sweep.
module spectrum_frame_buffer
    import spectrum_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int SHIFT = 8,
    parameter int DECAY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_W-1:0]   s_data,
    input  logic              s_last,
    input  logic              vblank,
    input  logic [BIN_AW-1:0] address,
    output logic [BIN_W-1:0]  data,
    output logic              frame_err
);
    localparam logic [BIN_AW-1:0] LAST_BIN = BIN_AW'(NUM_BINS - 1);

    state_t            state;
    logic [BIN_AW-1:0] cnt;
    logic              front;
    logic              disp_valid;
    logic              beat;
    logic [BIN_W-1:0]  v;
    logic              wr_en;
    logic [BIN_AW-1:0] wr_addr;
    logic [BIN_W-1:0]  wr_dat;
    logic              rd_vld_q;
    logic              rd_sel_q;
    logic [BIN_W-1:0]  rd_dat0;
    logic [BIN_W-1:0]  rd_dat1;

    assign beat = s_valid && s_ready;
    assign v    = sat8(32'(s_data >> SHIFT));

`ifdef PEAK_HOLD_EN
    localparam logic BEAT_GAP = 1'b1;

    logic              sweep;
    logic              pk_we;
    logic [BIN_AW-1:0] pk_addr;
    logic [BIN_W-1:0]  pk_v;
    logic [BIN_W-1:0]  pk_rd;
    logic [BIN_W-1:0]  pk_dec;
    logic [BIN_W-1:0]  pk_new;

    // Peak RAM is read at the beat and rewritten the following cycle; the sweep reuses cnt as address.
    spectrum_bank_ram u_peak_ram (
        .clk   (clk),
        .we    (sweep || pk_we),
        .waddr (sweep ? cnt : pk_addr),
        .wdata (sweep ? '0 : pk_new),
        .raddr (cnt),
        .rdata (pk_rd)
    );

    assign pk_dec = (32'(pk_rd) > 32'(DECAY)) ? BIN_W'(32'(pk_rd) - 32'(DECAY)) : '0;
    assign pk_new = (pk_v > pk_dec) ? pk_v : pk_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            pk_we <= 1'b0;
        end else begin
            pk_we <= beat;
        end
        if (beat) begin
            pk_addr <= cnt;
            pk_v    <= v;
        end
    end

    assign wr_en   = pk_we;
    assign wr_addr = pk_addr;
    assign wr_dat  = pk_new;
`else
    localparam logic BEAT_GAP = 1'b0;

    assign wr_en   = beat;
    assign wr_addr = cnt;
    assign wr_dat  = v;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            cnt        <= '0;
            front      <= 1'b0;
            disp_valid <= 1'b0;
            frame_err  <= 1'b0;
            s_ready    <= 1'b0;
`ifdef PEAK_HOLD_EN
            sweep      <= 1'b1;
`endif
        end
`ifdef PEAK_HOLD_EN
        else if (sweep) begin
            cnt <= cnt + BIN_AW'(1);
            if (cnt == LAST_BIN) begin
                sweep   <= 1'b0;
                s_ready <= 1'b1;
            end
        end
`endif
        else begin
            case (state)
                FILL: begin
                    s_ready <= !(beat && BEAT_GAP);
                    if (beat) begin
                        // A long frame is cut at bin 511 and still displayed.
                        if (cnt == LAST_BIN) begin
                            cnt     <= '0;
                            state   <= WAIT_SWAP;
                            s_ready <= 1'b0;
                            if (!s_last) frame_err <= 1'b1;
                        end else if (s_last) begin
                            cnt       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            cnt <= cnt + BIN_AW'(1);
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (vblank) begin
                        front      <= !front;
                        disp_valid <= 1'b1;
                        state      <= FILL;
                        s_ready    <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Writes always go to the back bank, i.e. the one not selected by front.
    spectrum_bank_ram u_bank0 (
        .clk   (clk),
        .we    (wr_en && front),
        .waddr (wr_addr),
        .wdata (wr_dat),
        .raddr (address),
        .rdata (rd_dat0)
    );

    spectrum_bank_ram u_bank1 (
        .clk   (clk),
        .we    (wr_en && !front),
        .waddr (wr_addr),
        .wdata (wr_dat),
        .raddr (address),
        .rdata (rd_dat1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            rd_vld_q <= disp_valid;
            rd_sel_q <= front;
        end
    end

    assign data = rd_vld_q ? (rd_sel_q ? rd_dat1 : rd_dat0) : '0;
endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// Randomized bench for spectrum_frame_buffer: frame-level reference model plus literal spot checks.
module tb_spectrum_frame_buffer;
    localparam int SHIFT = 8;
    localparam int DECAY = 2;
`ifdef PEAK_HOLD_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif
    localparam int LOW_EXP = PEAK ? 253 : 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        vblank = 1'b0;
    logic [15:0] s_data = '0;
    logic [8:0]  address = '0;
    logic        s_ready;
    logic [7:0]  data;
    logic        frame_err;

    spectrum_frame_buffer #(.IN_W(16), .SHIFT(SHIFT), .DECAY(DECAY)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .vblank    (vblank),
        .address   (address),
        .data      (data),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int first_beat = 0;
    int last_beat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frames are whole arrays; the displayed frame is the last complete one
    // that met a vblank. No banks, only what the viewer should see.
    logic [7:0] disp_m [512];
    logic [7:0] cur_m  [512];
    logic [7:0] pend_m [512];
    logic [7:0] peak_m [512];
    bit         m_dvalid, m_pending, m_ready, m_err;
    int         m_idx, m_sweep;
    logic [7:0] m_data;

    function automatic logic [7:0] scale(input logic [15:0] d);
        int x;
        x = int'(d) / (1 << SHIFT);
        return (x > 255) ? 8'd255 : 8'(x);
    endfunction

    always @(posedge clk) begin : model
        bit         beat;
        logic [7:0] v;
        int         dec;
        cyc++;
        if (rst) begin
            m_idx = 0; m_pending = 0; m_dvalid = 0; m_err = 0; m_ready = 0; m_data = '0;
            m_sweep = PEAK ? 512 : 0;
            foreach (peak_m[i]) peak_m[i] = '0;
        end else begin
            beat   = s_valid && m_ready;
            m_data = m_dvalid ? disp_m[address] : 8'd0;
            if (m_sweep > 0) begin
                m_sweep--;
                m_ready = (m_sweep == 0);
            end else if (m_pending) begin
                if (vblank) begin
                    disp_m = pend_m; m_dvalid = 1; m_pending = 0; m_ready = 1;
                end
            end else begin
                m_ready = !(PEAK && beat);
                if (beat) begin
                    v = scale(s_data);
                    if (PEAK) begin
                        dec = (int'(peak_m[m_idx]) > DECAY) ? int'(peak_m[m_idx]) - DECAY : 0;
                        if (dec > int'(v)) v = 8'(dec);
                        peak_m[m_idx] = v;
                    end
                    cur_m[m_idx] = v;
                    if (m_idx == 511) begin
                        pend_m = cur_m; m_pending = 1; m_ready = 0; m_idx = 0;
                        if (!s_last) m_err = 1;
                    end else if (s_last) begin
                        m_err = 1; m_idx = 0;
                    end else begin
                        m_idx++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("s_ready", s_ready, m_ready);
            check("data", data, m_data);
            check("frame_err", frame_err, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rand_vb);
        s_valid = 0;
        repeat (n) begin
            vblank  = rand_vb && ($urandom_range(0, 3) == 0);
            address = 9'($urandom_range(0, 511));
            step();
        end
        vblank = 0;
    endtask

    task automatic pulse_vblank();
        vblank = 1;
        step();
        vblank = 0;
    endtask

    task automatic send_beat(input logic [15:0] d, input bit last, input bit vb);
        bit acc;
        int guard;
        guard = 0;
        s_valid = 1; s_data = d; s_last = last; vblank = vb;
        do begin
            acc     = s_ready;
            address = 9'($urandom_range(0, 511));
            step();
            guard++;
        end while (!acc && guard < 2000);
        if (!acc) check("accept_timeout", 32'(acc), 1);
        last_beat = cyc;
        s_valid = 0; s_last = 0; vblank = 0;
    endtask

    // kind: 0 ramp k<<8, 1 constant cval, 2 random
    task automatic send_frame(input int kind, input logic [15:0] cval, input int n,
                              input bit with_last, input bit gaps, input bit vb_last);
        for (int k = 0; k < n; k++) begin
            logic [15:0] d;
            case (kind)
                0:       d = 16'(k << 8);
                1:       d = cval;
                default: d = 16'($urandom);
            endcase
            send_beat(d, with_last && (k == n - 1), vb_last && (k == n - 1));
            if (k == 0) first_beat = last_beat;
            if (gaps && k < n - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1);
        end
    endtask

    task automatic read_chk(input string name, input int a, input int exp);
        s_valid = 0;
        address = 9'(a);
        step();
        check(name, data, exp);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        step();
        chk_en = 1;
        step();
        check("rst_s_ready", s_ready, 0);
        check("rst_data", data, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 0;
        step();
`ifndef PEAK_HOLD_EN
        check("ready_after_rst", s_ready, 1);
`endif

        // Ramp frame: nothing shown before vblank, k mod 256 after.
        send_frame(0, '0, 512, 1, 1, 0);
        read_chk("pre_vblank", 10, 0);
        pulse_vblank();
        read_chk("ramp_5", 5, 5);
        read_chk("ramp_300", 300, 44);
        read_chk("ramp_511", 511, 255);

        // Saturated and all-below-shift frames.
        send_frame(1, 16'hFFFF, 512, 1, 1, 0);
        pulse_vblank();
        read_chk("sat_0", 0, 255);
        read_chk("sat_rand", $urandom_range(0, 511), 255);
        send_frame(1, 16'h00FF, 512, 1, 1, 0);
        pulse_vblank();
        read_chk("low_rand", $urandom_range(0, 511), LOW_EXP);

        // Short frame is dropped and flags the error.
        send_frame(1, 16'h1100, 101, 1, 1, 0);
        step();
        check("short_err", frame_err, 1);
        pulse_vblank();
        read_chk("short_no_swap", 7, LOW_EXP);
        send_frame(2, '0, 512, 1, 1, 0);
        pulse_vblank();
        idle(20, 0);

        // Completed frame holds off the source until vblank.
        send_frame(2, '0, 512, 1, 0, 0);
        s_valid = 1; s_data = 16'h1234; s_last = 0;
        repeat (5) begin
            step();
            check("hold_ready", s_ready, 0);
        end
        vblank = 1;
        step();
        vblank = 0; s_valid = 0;
        check("ready_after_swap", s_ready, 1);
        idle(20, 0);

        // vblank coinciding with the last beat must not swap.
        send_frame(1, 16'h3300, 512, 1, 1, 0);
        pulse_vblank();
        send_frame(1, 16'h4400, 512, 1, 1, 1);
        idle(2, 0);
`ifndef PEAK_HOLD_EN
        read_chk("vb_same_cycle", 3, 8'h33);
`endif
        check("err_sticky", frame_err, 1);
        pulse_vblank();
        read_chk("vb_next_swap", 3, 8'h44);

        // Reset in mid-frame clears display and error.
        send_frame(2, '0, 50, 0, 1, 0);
        rst = 1;
        step();
        check("midrst_data", data, 0);
        check("midrst_err", frame_err, 0);
        rst = 0;
        send_frame(2, '0, 512, 1, 1, 0);
        pulse_vblank();
        idle(20, 0);

        // Long frame: cut at bin 511, displayed, error flagged.
        send_frame(2, '0, 512, 0, 1, 0);
        step();
        check("long_err", frame_err, 1);
        pulse_vblank();
        idle(20, 0);

        for (int f = 0; f < 6; f++) begin
            int r;
            r = $urandom_range(0, 5);
            if (r == 0)      send_frame(2, '0, $urandom_range(1, 511), 1, 1, 0);
            else if (r == 1) send_frame(2, '0, 512, 0, 1, 0);
            else             send_frame(2, '0, 512, 1, 1, $urandom_range(0, 1) == 1);
            idle($urandom_range(0, 3), 0);
            pulse_vblank();
            idle(15, 0);
        end

`ifdef PEAK_HOLD_EN
        rst = 1;
        step();
        rst = 0;
        send_frame(1, 16'(200 << 8), 512, 1, 0, 0);
        check("peak_throughput", 32'(last_beat - first_beat), 1022);
        pulse_vblank();
        read_chk("peak_a", 17, 200);
        send_frame(1, 16'h0000, 512, 1, 0, 0);
        pulse_vblank();
        read_chk("peak_b", 17, 198);
`endif

        idle(3, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
